// File: rtl/fp16_mul_sched.sv
// fp16_mul_sched: round-robin scheduler sharing one external fp16 multiplier among NREQ
// requesters, followed by a two-stage valid/ready pipeline.
//
// Ports:
//   CLK, RST            clock; asynchronous active-high reset
//   req_valid/req_ready per-requester handshake (req_ready is one-hot or zero)
//   req_a, req_b        packed operands, requester i at [i*DWIDTH +: DWIDTH]
//   mul_a, mul_b        stage-1 operands driven to the external multiplier
//   mul_sign/sum/carry/exponent  combinational multiplier result for mul_a/mul_b
//   o_valid/o_ready     result handshake
//   o_tag               index of the requester that issued the result
//   o_sign/sum/carry/exponent/zero  registered multiplier result and zero-operand flag
//   busy                either pipeline stage holds a valid entry
module fp16_mul_sched #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned DWIDTH = 16,
  parameter int unsigned EWIDTH = 5,
  parameter int unsigned MWIDTH = 10,
  localparam int unsigned TW    = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int unsigned PW    = 2 * MWIDTH + 2
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*DWIDTH-1:0]    req_a,
  input  logic [NREQ*DWIDTH-1:0]    req_b,
  output logic [DWIDTH-1:0]         mul_a,
  output logic [DWIDTH-1:0]         mul_b,
  input  logic                      mul_sign,
  input  logic [PW-1:0]             mul_sum,
  input  logic [PW-1:0]             mul_carry,
  input  logic signed [EWIDTH:0]    mul_exponent,
  output logic                      o_valid,
  input  logic                      o_ready,
  output logic [TW-1:0]             o_tag,
  output logic                      o_sign,
  output logic [PW-1:0]             o_sum,
  output logic [PW-1:0]             o_carry,
  output logic signed [EWIDTH:0]    o_exponent,
  output logic                      o_zero,
  output logic                      busy
);

  logic                     s1_v_q, s1_v_d;
  logic [DWIDTH-1:0]        s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic [TW-1:0]            s1_tag_q, s1_tag_d;
  logic [TW-1:0]            ptr_q, ptr_d;

  logic                     s2_v_q, s2_v_d;
  logic [TW-1:0]            s2_tag_q, s2_tag_d;
  logic                     s2_sign_q, s2_sign_d;
  logic [PW-1:0]            s2_sum_q, s2_sum_d, s2_carry_q, s2_carry_d;
  logic signed [EWIDTH:0]   s2_exp_q, s2_exp_d;
  logic                     s2_zero_q, s2_zero_d;

  logic                     adv2, ld1, hs, grant_any, s1_zero;
  logic [TW-1:0]            grant_idx, idx;
  logic [NREQ-1:0]          grant;

  // Round-robin: first valid requester scanning upward from ptr, wrapping.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = TW'((32'(ptr_q) + k) % NREQ);
      if (!grant_any && req_valid[idx]) begin
        grant_any      = 1'b1;
        grant_idx      = idx;
        grant[idx]     = 1'b1;
      end
    end
  end

  // Zero operand: exponent and mantissa both zero, sign ignored.
  assign s1_zero = ~|s1_a_q[DWIDTH-2:0] | ~|s1_b_q[DWIDTH-2:0];

  always_comb begin
    adv2       = ~s2_v_q | o_ready;
    ld1        = ~s1_v_q | adv2;
    hs         = grant_any & ld1;
    // grant alone would be live during reset because s1_v is cleared, so gate it
    req_ready  = RST ? '0 : (grant & {NREQ{ld1}});

    s1_v_d     = s1_v_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_tag_d   = s1_tag_q;
    ptr_d      = ptr_q;
    if (ld1) begin
      s1_v_d = hs;
      if (hs) begin
        s1_a_d   = req_a[32'(grant_idx) * DWIDTH +: DWIDTH];
        s1_b_d   = req_b[32'(grant_idx) * DWIDTH +: DWIDTH];
        s1_tag_d = grant_idx;
        ptr_d    = (grant_idx == TW'(NREQ - 1)) ? '0 : grant_idx + TW'(1);
      end
    end

    s2_v_d     = s2_v_q;
    s2_tag_d   = s2_tag_q;
    s2_sign_d  = s2_sign_q;
    s2_sum_d   = s2_sum_q;
    s2_carry_d = s2_carry_q;
    s2_exp_d   = s2_exp_q;
    s2_zero_d  = s2_zero_q;
    if (adv2) begin
      s2_v_d     = s1_v_q;
      s2_tag_d   = s1_tag_q;
      s2_sign_d  = mul_sign;
      s2_sum_d   = mul_sum;
      s2_carry_d = mul_carry;
      s2_exp_d   = mul_exponent;
      s2_zero_d  = s1_zero;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_v_q     <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_tag_q   <= '0;
      ptr_q      <= '0;
      s2_v_q     <= 1'b0;
      s2_tag_q   <= '0;
      s2_sign_q  <= 1'b0;
      s2_sum_q   <= '0;
      s2_carry_q <= '0;
      s2_exp_q   <= '0;
      s2_zero_q  <= 1'b0;
    end else begin
      s1_v_q     <= s1_v_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_tag_q   <= s1_tag_d;
      ptr_q      <= ptr_d;
      s2_v_q     <= s2_v_d;
      s2_tag_q   <= s2_tag_d;
      s2_sign_q  <= s2_sign_d;
      s2_sum_q   <= s2_sum_d;
      s2_carry_q <= s2_carry_d;
      s2_exp_q   <= s2_exp_d;
      s2_zero_q  <= s2_zero_d;
    end
  end

  assign mul_a      = s1_a_q;
  assign mul_b      = s1_b_q;
  assign o_valid    = s2_v_q;
  assign o_tag      = s2_tag_q;
  assign o_sign     = s2_sign_q;
  assign o_sum      = s2_sum_q;
  assign o_carry    = s2_carry_q;
  assign o_exponent = s2_exp_q;
  assign o_zero     = s2_zero_q;
  assign busy       = s1_v_q | s2_v_q;

endmodule

// File: tb/tb_fp16_mul_sched.sv
// Scoreboard bench for fp16_mul_sched with a behavioural external multiplier.
module tb_fp16_mul_sched;
  localparam int NREQ = 4;
  localparam int DW   = 16;
  localparam int PW   = 22;
  localparam logic [PW-1:0] CMASK = 22'h0A5A5A;

  // Directed vectors with hand-computed products (hidden-bit mantissas) and unbiased exponents.
  localparam logic [15:0] VA [8] = '{16'h3C00, 16'h0001, 16'h4200, 16'h3800,
                                     16'h7BFF, 16'h0000, 16'h3E00, 16'h0400};
  localparam logic [15:0] VB [8] = '{16'h4000, 16'h8000, 16'hC400, 16'h3800,
                                     16'h3C00, 16'h3C00, 16'h3E00, 16'h0400};
  localparam logic [PW-1:0] EP [8] = '{22'h100000, 22'h000000, 22'h180000, 22'h100000,
                                       22'h1FFC00, 22'h000000, 22'h240000, 22'h100000};
  localparam int   EE [8] = '{1, -28, 3, -2, 15, -14, 0, -28};
  localparam logic ES [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic EZ [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  logic                 CLK, RST;
  logic [NREQ-1:0]      req_valid, req_ready;
  logic [NREQ*DW-1:0]   req_a, req_b;
  logic [DW-1:0]        mul_a, mul_b;
  logic                 mul_sign;
  logic [PW-1:0]        mul_sum, mul_carry;
  logic signed [5:0]    mul_exponent;
  logic                 o_valid, o_ready;
  logic [1:0]           o_tag;
  logic                 o_sign;
  logic [PW-1:0]        o_sum, o_carry;
  logic signed [5:0]    o_exponent;
  logic                 o_zero, busy;

  fp16_mul_sched dut (
    .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .mul_a(mul_a), .mul_b(mul_b),
    .mul_sign(mul_sign), .mul_sum(mul_sum), .mul_carry(mul_carry),
    .mul_exponent(mul_exponent), .o_valid(o_valid), .o_ready(o_ready),
    .o_tag(o_tag), .o_sign(o_sign), .o_sum(o_sum), .o_carry(o_carry),
    .o_exponent(o_exponent), .o_zero(o_zero), .busy(busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // External multiplier model: product split into sum/carry halves by a fixed mask.
  logic [21:0] prod;
  int          ea, eb;
  always_comb begin
    mul_sign     = mul_a[15] ^ mul_b[15];
    prod         = {11'b0, (mul_a[14:10] != 0), mul_a[9:0]} *
                   {11'b0, (mul_b[14:10] != 0), mul_b[9:0]};
    ea           = (mul_a[14:10] == 0) ? -14 : int'(mul_a[14:10]) - 15;
    eb           = (mul_b[14:10] == 0) ? -14 : int'(mul_b[14:10]) - 15;
    mul_exponent = 6'(ea + eb);
    mul_carry    = prod & CMASK;
    mul_sum      = prod & ~CMASK;
  end

  // Per-requester lists of vector indices.
  int rl [4][16];
  int rh [4] = '{default: 0};
  int rt [4] = '{default: 0};

  task automatic enq(input int r, input int v);
    rl[r][rt[r]] = v;
    rt[r]++;
  endtask

  function automatic bit any_pend();
    for (int i = 0; i < NREQ; i++) if (rh[i] != rt[i]) return 1'b1;
    return 1'b0;
  endfunction

  always_comb begin
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (rh[i] != rt[i]) begin
        req_valid[i]       = 1'b1;
        req_a[i*DW +: DW]  = VA[rl[i][rh[i]]];
        req_b[i*DW +: DW]  = VB[rl[i][rh[i]]];
      end
    end
  end

  typedef struct packed {
    logic [1:0] tag;
    logic [2:0] vec;
  } sb_t;

  sb_t             sb [$];
  sb_t             hs_ent;
  int              hs_log [$];
  int              hs_cyc [$];
  logic [NREQ-1:0] hs_pend = '0;
  int              cyc = 0;

  // Handshake observer: inputs are stable from negedge to posedge, so this is the accept.
  always @(negedge CLK) begin
    hs_pend = '0;
    if (!RST) begin
      check("ready_onehot", {63'b0, ($countones(req_ready) <= 1)}, 64'd1);
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          hs_pend[i] = 1'b1;
          hs_ent.tag = 2'(i);
          hs_ent.vec = 3'(rl[i][rh[i]]);
          sb.push_back(hs_ent);
          hs_log.push_back(i);
          hs_cyc.push_back(cyc);
        end
      end
    end
  end

  always @(posedge CLK) begin
    cyc++;
    #1;
    for (int i = 0; i < NREQ; i++) if (hs_pend[i]) rh[i]++;
  end

  // Monitor: compare every accepted result against the oldest expectation.
  sb_t mon_e;
  always @(negedge CLK) begin
    if (!RST && o_valid && o_ready) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_result: got tag %0d, expected no result", o_tag);
      end else begin
        mon_e = sb.pop_front();
        check("res_tag",   {62'b0, o_tag},      {62'b0, mon_e.tag});
        check("res_sign",  {63'b0, o_sign},     {63'b0, ES[mon_e.vec]});
        check("res_sum",   {42'b0, o_sum},      {42'b0, EP[mon_e.vec] & ~CMASK});
        check("res_carry", {42'b0, o_carry},    {42'b0, EP[mon_e.vec] & CMASK});
        check("res_exp",   {58'b0, o_exponent}, {58'b0, 6'(EE[mon_e.vec])});
        check("res_zero",  {63'b0, o_zero},     {63'b0, EZ[mon_e.vec]});
      end
    end
  end

  function automatic logic [63:0] out_vec();
    return {10'b0, o_tag, o_sign, o_sum, o_carry, o_exponent, o_zero};
  endfunction

  task automatic wait_drain(input string name);
    int n = 0;
    while ((sb.size() != 0 || busy || any_pend()) && n < 60) begin
      @(posedge CLK);
      #1;
      n++;
    end
    check(name, {63'b0, (sb.size() == 0 && !busy && !any_pend())}, 64'd1);
  endtask

  logic [63:0] snap;

  initial begin
    RST     = 1'b1;
    o_ready = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_valid", {63'b0, o_valid}, 64'd0);
    check("rst_busy",  {63'b0, busy},    64'd0);
    check("rst_ready", {60'b0, req_ready}, 64'd0);
    check("rst_outs",  out_vec(), 64'd0);
    RST = 1'b0;
    @(posedge CLK);
    #1;

    // Single op on requester 0 with latency probe.
    enq(0, 0);
    @(posedge CLK);
    #1;
    check("lat_s1_busy",  {63'b0, busy},    64'd1);
    check("lat_early",    {63'b0, o_valid}, 64'd0);
    @(posedge CLK);
    #1;
    check("lat_two",      {63'b0, o_valid}, 64'd1);
    check("lat_tag",      {62'b0, o_tag},   64'd0);
    wait_drain("drain_single");

    // Subnormal x negative zero on requester 2, then requester 3 to bring ptr back to 0.
    enq(2, 1);
    wait_drain("drain_subnormal");
    enq(3, 2);
    wait_drain("drain_req3");

    // Fairness: all four requesters hold two requests each.
    hs_log.delete();
    hs_cyc.delete();
    for (int i = 0; i < NREQ; i++) begin
      enq(i, 4 + i);
      enq(i, i);
    end
    wait_drain("drain_fair");
    check("fair_count", 64'(hs_log.size()), 64'd8);
    for (int j = 0; j < 8; j++)
      check("fair_tag", 64'((j < hs_log.size()) ? hs_log[j] : 99), 64'(j % 4));
    check("fair_b2b", 64'((hs_cyc.size() == 8) ? hs_cyc[7] - hs_cyc[0] : -1), 64'd7);

    // Backpressure: stall five cycles with four requests pending.
    o_ready = 1'b0;
    hs_log.delete();
    enq(0, 1);
    enq(1, 2);
    enq(2, 5);
    enq(3, 6);
    repeat (3) @(posedge CLK);
    #1;
    snap = out_vec();
    repeat (2) @(posedge CLK);
    #1;
    check("bp_accepts", 64'(hs_log.size()), 64'd2);
    check("bp_ready",   {60'b0, req_ready}, 64'd0);
    check("bp_valid",   {63'b0, o_valid},   64'd1);
    check("bp_stable",  out_vec(), snap);
    o_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge CLK);
      check("bp_nogap", {63'b0, o_valid}, 64'd1);
    end
    wait_drain("drain_bp");

    // Reset mid-stream with both stages full and ptr at 2.
    o_ready = 1'b0;
    enq(0, 2);
    enq(1, 3);
    repeat (3) @(posedge CLK);
    #1;
    check("mid_full_busy",  {63'b0, busy},    64'd1);
    check("mid_full_valid", {63'b0, o_valid}, 64'd1);
    enq(1, 4);
    enq(3, 7);
    @(negedge CLK);
    #2;
    RST = 1'b1;
    #1;
    check("mid_rst_valid", {63'b0, o_valid},   64'd0);
    check("mid_rst_busy",  {63'b0, busy},      64'd0);
    check("mid_rst_ready", {60'b0, req_ready}, 64'd0);
    check("mid_rst_outs",  out_vec(), 64'd0);
    sb.delete();
    hs_log.delete();
    @(posedge CLK);
    #1;
    RST     = 1'b0;
    o_ready = 1'b1;
    wait_drain("drain_after_rst");
    check("first_grant", 64'((hs_log.size() > 0) ? hs_log[0] : 99), 64'd1);
    repeat (5) @(posedge CLK);
    #1;
    check("idle_final", {63'b0, (o_valid || busy || sb.size() != 0)}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fp16_mul_sched.md
FP16_MUL_SCHED -- requirements
Module: fp16_mul_sched

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing one fp16 multiplier.
REQ-002 Parameter DWIDTH, default 16: operand width.
REQ-003 Parameter EWIDTH, default 5; parameter MWIDTH, default 10. TW = clog2(NREQ).
REQ-004 CLK  input  1  clock; the block uses one clock.
REQ-005 RST  input  1  reset, asynchronous, active-high.
REQ-006 req_valid  input  NREQ  per-requester operand-pair valid.
REQ-007 req_ready  output  NREQ  per-requester accept; at most one bit high per cycle.
REQ-008 req_a, req_b  input  NREQ*DWIDTH each  packed fp16 operands; requester i uses bits [i*DWIDTH +: DWIDTH].
REQ-009 mul_a, mul_b  output  DWIDTH each  operands driven to the external multiplier, taken from stage-1 registers.
REQ-010 mul_sign  input  1; mul_sum, mul_carry  input  2*MWIDTH+2 each; mul_exponent  input  EWIDTH+1 (signed): combinational multiplier result for mul_a/mul_b.
REQ-011 o_valid  output  1  result valid.
REQ-012 o_ready  input  1  downstream accept.
REQ-013 o_tag  output  TW  index of the requester that issued the result.
REQ-014 o_sign, o_sum, o_carry, o_exponent  outputs  1, 2*MWIDTH+2, 2*MWIDTH+2, EWIDTH+1  registered multiplier result.
REQ-015 o_zero  output  1  high when either issued operand had exponent and mantissa both zero.
REQ-016 busy  output  1  high when either pipeline stage holds a valid entry.

Function
REQ-017 The pipeline has two stages: S1 (operands and tag) and S2 (result, tag, zero flag), each with a valid bit.
REQ-018 S2 advance: adv2 = ~s2_v | o_ready; S1 load enable: ld1 = ~s1_v | adv2.
REQ-019 Arbitration is round-robin: grant the lowest index i at or after pointer ptr, wrapping modulo NREQ, with req_valid[i]=1.
REQ-020 req_ready[i] = grant[i] & ld1, combinational from req_valid; a handshake is req_valid[i] & req_ready[i].
REQ-021 On a handshake with requester i: S1 captures req_a[i], req_b[i], tag=i and s1_v=1; ptr becomes (i+1) mod NREQ.
REQ-022 When ld1=1 and no handshake occurs, s1_v becomes 0 and ptr holds.
REQ-023 When adv2=1: S2 captures mul_* inputs, S1 tag and zero flag, and s2_v takes the value of s1_v; otherwise S2 holds.
REQ-024 Latency is 2 cycles: a handshake at edge k gives o_valid=1 after edge k+1, provided o_ready was not low with S2 full.
REQ-025 Throughput is one result per cycle while o_ready=1; when o_ready=0 the pipeline stalls with no loss or duplication.
REQ-026 Results leave in the order they were accepted.
REQ-027 o_* outputs are the S2 registers, and o_valid = s2_v.
REQ-028 mul_a/mul_b hold the S1 contents; when s1_v=0 they are undefined and ignored.
REQ-029 With a single active requester, that requester is granted every cycle ld1=1.
REQ-030 With all requesters continuously valid, grants rotate 0,1,...,NREQ-1,0,...
REQ-031 A requester dropping req_valid before its handshake causes no state change.

Reset
REQ-032 While RST=1 (asynchronous): s1_v=0, s2_v=0, ptr=0, and o_tag, o_sign, o_sum, o_carry, o_exponent and o_zero are all 0.
REQ-033 While RST=1: o_valid=0, busy=0, req_ready=0.
REQ-034 Reset asserted mid-operation discards in-flight entries without emitting them; operation resumes on the first edge after RST falls.

Verification
REQ-035 Single op: req 0 issues a=0x3C00, b=0x4000, o_ready=1 -> 2 cycles later o_valid=1, o_tag=0, o_sign=0, (o_sum+o_carry) mod 2^22 = 0x100000, o_exponent=+1.
REQ-036 Subnormal/zero: req 2 issues a=0x0001, b=0x8000 -> o_zero=1, o_sign=1, o_exponent=-28, o_tag=2.
REQ-037 Fairness: all four requesters valid for 8 cycles with o_ready=1 -> o_tag sequence 0,1,2,3,0,1,2,3 and one handshake per cycle.
REQ-038 Backpressure: o_ready=0 for 5 cycles with requests pending -> S1 and S2 fill, req_ready=0 after 2 accepts, outputs stable; on o_ready=1, results drain in order with no gap.
REQ-039 Reset mid-stream: RST pulsed while s1_v=s2_v=1 -> o_valid=0 and busy=0 immediately; no stale result afterward; the first grant after reset goes to the lowest valid index.
